// File: rtl/find_extremes_pkg.sv
// Shared definitions for the find_extremes block: FSM state encoding and
// width-independent constants.
package find_extremes_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RECEIVING = 2'd1,
        DONE      = 2'd2
    } state_t;

    localparam int MIN_WIDTH = 2;
    localparam int MAX_WIDTH = 32;

    // Samples are accepted in every state except DONE.
    function automatic logic can_accept(input state_t s);
        return (s == IDLE) || (s == RECEIVING);
    endfunction

endpackage

// File: rtl/extreme_compare.sv
// Magnitude comparison of one sample against the stored maximum and minimum,
// unsigned or two's complement depending on SIGNED_MODE.
module extreme_compare #(
    parameter int WIDTH       = 8,
    parameter int SIGNED_MODE = 0
) (
    input  logic [WIDTH-1:0] sample,
    input  logic [WIDTH-1:0] max_val,
    input  logic [WIDTH-1:0] min_val,
    output logic             gt,
    output logic             lt
);

    generate
        if (SIGNED_MODE != 0) begin : g_signed
            assign gt = $signed(sample) > $signed(max_val);
            assign lt = $signed(sample) < $signed(min_val);
        end else begin : g_unsigned
            assign gt = sample > max_val;
            assign lt = sample < min_val;
        end
    endgenerate

endmodule

// File: rtl/find_extremes.sv
// Tracks maximum/minimum of a framed sample stream with first-occurrence
// indexes, a saturating sample count and a one-cycle done pulse.
module find_extremes
    import find_extremes_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int CNT_W       = 16,
    parameter int SIGNED_MODE = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             valid,
    input  logic [WIDTH-1:0] inputA,
    output logic [WIDTH-1:0] maxValue,
    output logic [WIDTH-1:0] minValue,
    output logic [CNT_W-1:0] maxIndex,
    output logic [CNT_W-1:0] minIndex,
    output logic [CNT_W-1:0] count,
    output logic             empty,
    output logic             overflow,
    output logic             done,
    output state_t           dbg_state
);

    // Framing: start stays high for a whole sequence and its falling edge
    // closes it; valid qualifies inputA only while start is high. There is
    // no backpressure, every qualified sample outside DONE is consumed.

    localparam logic [WIDTH-1:0] VAL_LO = (SIGNED_MODE != 0) ?
        {1'b1, {(WIDTH-1){1'b0}}} : {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] VAL_HI = (SIGNED_MODE != 0) ?
        {1'b0, {(WIDTH-1){1'b1}}} : {WIDTH{1'b1}};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t state;
    state_t state_next;
    logic   accept;
    logic   new_seq;
    logic   cnt_sat;
    logic   is_gt;
    logic   is_lt;

    assign accept    = start & valid & can_accept(state);
    assign new_seq   = (state == IDLE) & start;
    assign cnt_sat   = (count == CNT_MAX);
    assign dbg_state = state;

    extreme_compare #(
        .WIDTH       (WIDTH),
        .SIGNED_MODE (SIGNED_MODE)
    ) u_cmp (
        .sample  (inputA),
        .max_val (maxValue),
        .min_val (minValue),
        .gt      (is_gt),
        .lt      (is_lt)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:      if (start)  state_next = RECEIVING;
            RECEIVING: if (!start) state_next = DONE;
            DONE:      state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            done     <= 1'b0;
            count    <= '0;
            overflow <= 1'b0;
            empty    <= 1'b1;
            maxIndex <= '0;
            minIndex <= '0;
            maxValue <= VAL_LO;
            minValue <= VAL_HI;
        end else begin
            done <= (state_next == DONE);
            if (new_seq) begin
                overflow <= 1'b0;
                if (valid) begin
                    maxValue <= inputA;
                    minValue <= inputA;
                    maxIndex <= '0;
                    minIndex <= '0;
                    count    <= CNT_W'(1);
                    empty    <= 1'b0;
                end else begin
                    count <= '0;
                    empty <= 1'b1;
                end
            end else if (accept) begin
                // A sequence opened without a sample loads both extremes
                // from its first accepted sample, regardless of prior values.
                if (empty) begin
                    maxValue <= inputA;
                    minValue <= inputA;
                    maxIndex <= count;
                    minIndex <= count;
                end else begin
                    if (is_gt) begin
                        maxValue <= inputA;
                        maxIndex <= count;
                    end
                    if (is_lt) begin
                        minValue <= inputA;
                        minIndex <= count;
                    end
                end
                empty <= 1'b0;
                if (cnt_sat) begin
                    overflow <= 1'b1;
                end else begin
                    count <= count + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: doc/find_extremes.md
FIND_EXTREMES -- requirements
Module: find_extremes

Interface
REQ-001 Parameter WIDTH, default 8, sample width in bits (2..32).
REQ-002 Parameter CNT_W, default 16, width of sample counter and index outputs.
REQ-003 Parameter SIGNED_MODE, default 0: 0 compares unsigned, 1 compares two's complement.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 start  input  1  held high for the duration of a sequence; falling edge ends it.
REQ-007 valid  input  1  inputA carries a sample this cycle.
REQ-008 inputA  input  WIDTH  sample data.
REQ-009 maxValue  output  WIDTH  largest sample of the current/last sequence.
REQ-010 minValue  output  WIDTH  smallest sample of the current/last sequence.
REQ-011 maxIndex  output  CNT_W  zero-based position of first occurrence of maxValue.
REQ-012 minIndex  output  CNT_W  zero-based position of first occurrence of minValue.
REQ-013 count  output  CNT_W  number of samples accepted in the sequence.
REQ-014 empty  output  1  high while the last/current sequence has accepted no samples.
REQ-015 overflow  output  1  sticky: count saturated during this sequence.
REQ-016 done  output  1  one-cycle pulse marking final results.

Function
REQ-017 FSM states IDLE, RECEIVING, DONE; IDLE->RECEIVING when start=1; RECEIVING->DONE when start=0; DONE->IDLE unconditionally.
REQ-018 Sample accepted on a cycle when start=1, valid=1 and state is IDLE or RECEIVING; no sample accepted in DONE.
REQ-019 Accepting in IDLE (new sequence) clears count/overflow/empty context first: sample loads maxValue and minValue, both indexes=0, count=1, empty=0.
REQ-020 IDLE with start=1, valid=0 starts a sequence with count=0, empty=1, overflow=0; maxValue/minValue hold prior values until first accepted sample, which loads both.
REQ-021 Subsequent accepted sample: maxValue/maxIndex update only if sample strictly greater; minValue/minIndex update only if strictly less; both may update in the same cycle; index = count value before increment.
REQ-022 Comparison per SIGNED_MODE; same bit pattern compares differently in the two modes.
REQ-023 count increments by 1 per accepted sample; at 2^CNT_W-1 it holds, overflow sets and stays set until next sequence start; comparisons continue, indexes of later extremes saturate at 2^CNT_W-1.
REQ-024 done=1 exactly in the cycle the FSM is in DONE (one cycle after start observed low in RECEIVING); registered output, no combinational path from inputs.
REQ-025 All result outputs remain stable from DONE until the first cycle of the next sequence; start high during DONE is ignored, re-evaluated in IDLE next cycle.
REQ-026 valid=1 with start=0 is ignored in every state.
REQ-027 Latency: an accepted sample is reflected on outputs the following cycle.

Reset
REQ-028 reset=1 at a clock edge forces state IDLE, done=0, count=0, overflow=0, empty=1, maxIndex=0, minIndex=0, regardless of state, including mid-sequence.
REQ-029 Reset maxValue = smallest representable (0 unsigned, 1000..0 signed); minValue = largest representable (all ones unsigned, 0111..1 signed).
REQ-030 reset has priority over start and valid in the same cycle.

Structure
REQ-031 State enum type (IDLE, RECEIVING, DONE) and width-independent constants live in the shared definitions package.
REQ-032 One sub-module, extreme_compare, parametrised by WIDTH and SIGNED_MODE, producing gt/lt flags for sample vs stored max/min.
REQ-033 Three-block FSM: state register, next-state combinational logic, registered outputs.

Verification
REQ-034 WIDTH=8 unsigned: start high, valid samples 5,200,3,200,3 then start low -> DONE cycle: max=200,maxIndex=1, min=3,minIndex=2, count=5, done one cycle.
REQ-035 SIGNED_MODE=1, WIDTH=8: samples 0x7F,0x80,0x00 -> max=0x7F idx0, min=0x80 idx1; same stimulus unsigned -> max=0x80 idx1, min=0x00 idx2.
REQ-036 Gaps: start high 6 cycles, valid only cycles 2 and 5 with 9,4 -> count=2, max=9 idx0, min=4 idx1; start high one cycle with valid=0 -> done with empty=1, count=0.
REQ-037 CNT_W=3: 9 samples, largest last -> count=7, overflow=1, maxIndex=7; next sequence clears overflow.
REQ-038 Assert reset mid-sequence after 3 samples -> next cycle all outputs at REQ-028/029 values, done=0; new sequence starts cleanly.
REQ-039 Back-to-back: start low one cycle then high again during DONE -> new sequence begins in IDLE next cycle; previous results held through DONE.
